// File: rtl/beat_sequencer.sv
// ---------------------------------------------------------------------------
// beat_sequencer
//   Control-tube sequencer. Holds the control instruction counter (CI) and
//   the present instruction (PI) and steps the scan/action beat cycle
//   S1 A1 S2 A2 S3 A3 S4 A4, four phases per beat (32 cycles/instruction).
//   All outputs are combinational decodes of the registered state/CI/PI.
//
// Ports
//   w_CLK, w_RST      clock, asynchronous active-high reset
//   w_RUN             start request (rising edge starts / resumes)
//   b_MS_DATA         store read data (bit 0 = LSB)
//   b_A_VALUE         accumulator contents, MSB is the sign
//   ms_ready_out/in   store read / write strobes
//   a_ready_out/in    accumulator compute / write strobes
//   w_HS, w_ACTION    scan / action beat in progress
//   b_MS_ADDR         store address
//   b_MS_ZERO         store clear mask
//   w_A_ZERO          force accumulator read path to zero
//   b_FST_OUT         PI function field
//   w_STOP            machine halted
// ---------------------------------------------------------------------------
module beat_sequencer #(
  parameter int LINE_LENGTH         = 40,
  parameter int INSTR_ADDR_BITS     = 10,
  parameter int INSTR_FUNCTION_BITS = 6,
  parameter logic [INSTR_FUNCTION_BITS-1:0] INST_CMP = 6'b000101,
  parameter logic [INSTR_FUNCTION_BITS-1:0] INST_JMP = 6'b001101,
  parameter logic [INSTR_FUNCTION_BITS-1:0] INST_STA = 6'b010100,
  parameter logic [INSTR_FUNCTION_BITS-1:0] INST_HLT = 6'b111111,
  parameter logic [INSTR_FUNCTION_BITS-1:0] INST_ADD = 6'b101100,
  parameter logic [INSTR_FUNCTION_BITS-1:0] INST_SHR = 6'b111110,
  parameter logic [INSTR_FUNCTION_BITS-1:0] INST_LDA = 6'b100000
) (
  input  logic                           w_CLK,
  input  logic                           w_RST,
  input  logic                           w_RUN,
  input  logic [LINE_LENGTH-1:0]         b_MS_DATA,
  input  logic [LINE_LENGTH-1:0]         b_A_VALUE,
  output logic                           ms_ready_out,
  output logic                           ms_ready_in,
  output logic                           a_ready_out,
  output logic                           a_ready_in,
  output logic                           w_HS,
  output logic                           w_ACTION,
  output logic [INSTR_ADDR_BITS-1:0]     b_MS_ADDR,
  output logic [LINE_LENGTH-1:0]         b_MS_ZERO,
  output logic                           w_A_ZERO,
  output logic [INSTR_FUNCTION_BITS-1:0] b_FST_OUT,
  output logic                           w_STOP
);

  localparam int PI_BITS = INSTR_ADDR_BITS + INSTR_FUNCTION_BITS;

  // Scan beats sit on odd codes and action beats on even non-zero codes,
  // so scan/action decode is a single bit test.
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_S1   = 4'd1;
  localparam logic [3:0] ST_A1   = 4'd2;
  localparam logic [3:0] ST_S2   = 4'd3;
  localparam logic [3:0] ST_A2   = 4'd4;
  localparam logic [3:0] ST_S3   = 4'd5;
  localparam logic [3:0] ST_A3   = 4'd6;
  localparam logic [3:0] ST_S4   = 4'd7;
  localparam logic [3:0] ST_A4   = 4'd8;

  localparam logic [INSTR_ADDR_BITS-1:0] CI_ONE = {{(INSTR_ADDR_BITS-1){1'b0}}, 1'b1};

  logic [3:0]                 r_state;
  logic [1:0]                 r_phase;
  logic [INSTR_ADDR_BITS-1:0] r_ci;
  logic [PI_BITS-1:0]         r_pi;
  logic                       r_stop;
  logic                       r_run_d;

  logic                           w_run_edge;
  logic [INSTR_ADDR_BITS-1:0]     w_pi_addr;
  logic [INSTR_FUNCTION_BITS-1:0] w_pi_fn;
  logic w_is_cmp, w_is_jmp, w_is_sta, w_is_hlt, w_is_lda, w_is_acc;
  logic w_scan, w_action, w_a2, w_a3;
  logic w_p0, w_p1, w_p2, w_p3;
  logic w_unused_bits;

  assign w_run_edge = w_RUN & ~r_run_d;
  assign w_pi_addr  = r_pi[INSTR_ADDR_BITS-1:0];
  assign w_pi_fn    = r_pi[PI_BITS-1:INSTR_ADDR_BITS];

  assign w_is_cmp = (w_pi_fn == INST_CMP);
  assign w_is_jmp = (w_pi_fn == INST_JMP);
  assign w_is_sta = (w_pi_fn == INST_STA);
  assign w_is_hlt = (w_pi_fn == INST_HLT);
  assign w_is_lda = (w_pi_fn == INST_LDA);
  // ADD, SHR, LDA and every unlisted code share the accumulator sequence.
  assign w_is_acc = ~(w_is_cmp | w_is_jmp | w_is_sta | w_is_hlt);

  // Bits not consumed by the sequencer; ADD/SHR are decoded by exclusion.
  assign w_unused_bits = ^{b_MS_DATA[LINE_LENGTH-1:PI_BITS], b_A_VALUE[LINE_LENGTH-2:0],
                           (w_pi_fn == INST_ADD), (w_pi_fn == INST_SHR)};

  always_ff @(posedge w_CLK or posedge w_RST) begin
    if (w_RST) begin
      r_state <= ST_IDLE;
      r_phase <= 2'd0;
      r_ci    <= '0;
      r_pi    <= '0;
      r_stop  <= 1'b0;
      r_run_d <= 1'b0;
    end else begin
      r_run_d <= w_RUN;
      if (r_state == ST_IDLE) begin
        if (w_run_edge) begin
          r_state <= ST_S1;
          r_phase <= 2'd0;
          r_stop  <= 1'b0;
        end
      end else begin
        r_phase <= r_phase + 2'd1;
        if (r_phase == 2'd3) begin
          if ((r_state == ST_A3) && w_is_hlt) begin
            r_state <= ST_IDLE;
            r_stop  <= 1'b1;
          end else if (r_state == ST_A4) begin
            r_state <= ST_S1;
          end else begin
            r_state <= r_state + 4'd1;
          end
        end
        if ((r_state == ST_A1) && (r_phase == 2'd3))
          r_ci <= r_ci + CI_ONE;
        if ((r_state == ST_A2) && (r_phase == 2'd1))
          r_pi <= b_MS_DATA[PI_BITS-1:0];
        // JMP / CMP land here, before the next A1 increment.
        if ((r_state == ST_A3) && (r_phase == 2'd1)) begin
          if (w_is_jmp)
            r_ci <= b_MS_DATA[INSTR_ADDR_BITS-1:0];
          else if (w_is_cmp && b_A_VALUE[LINE_LENGTH-1])
            r_ci <= r_ci + CI_ONE;
        end
      end
    end
  end

  assign w_scan   = (r_state != ST_IDLE) &  r_state[0];
  assign w_action = (r_state != ST_IDLE) & ~r_state[0];
  assign w_a2     = (r_state == ST_A2);
  assign w_a3     = (r_state == ST_A3);
  assign w_p0     = (r_phase == 2'd0);
  assign w_p1     = (r_phase == 2'd1);
  assign w_p2     = (r_phase == 2'd2);
  assign w_p3     = (r_phase == 2'd3);

  assign w_HS         = w_scan;
  assign w_ACTION     = w_action;
  assign ms_ready_in  = (w_scan & w_p3) | (w_a3 & w_is_sta & w_p3);
  assign ms_ready_out = (w_a2 & w_p0) | (w_a3 & w_p0 & (w_is_acc | w_is_jmp));
  assign a_ready_out  = w_a3 & w_is_acc & w_p1;
  assign a_ready_in   = w_a3 & w_is_acc & w_p2;
  assign w_A_ZERO     = w_a3 & w_is_lda & w_p1;
  assign b_MS_ZERO    = (w_a3 & w_is_sta & w_p3) ? {LINE_LENGTH{1'b1}} : {LINE_LENGTH{1'b0}};
  assign b_MS_ADDR    = w_a3 ? w_pi_addr : r_ci;
  assign b_FST_OUT    = w_pi_fn;
  assign w_STOP       = r_stop;

endmodule

// File: tb/tb_beat_sequencer.sv
// ---------------------------------------------------------------------------
// tb_beat_sequencer
//   Directed bench for beat_sequencer with a small store/accumulator
//   environment, a cycle-indexed instruction model compared every cycle,
//   and literal expectations taken from the timing rules.
// ---------------------------------------------------------------------------
module tb_beat_sequencer;

  localparam logic [5:0] OP_CMP = 6'b000101;
  localparam logic [5:0] OP_JMP = 6'b001101;
  localparam logic [5:0] OP_STA = 6'b010100;
  localparam logic [5:0] OP_HLT = 6'b111111;
  localparam logic [5:0] OP_SHR = 6'b111110;
  localparam logic [5:0] OP_LDA = 6'b100000;
  localparam logic [5:0] OP_ADD = 6'b101100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [39:0] ms_data = '0;
  logic [39:0] acc = '0;
  logic        ms_ready_out, ms_ready_in, a_ready_out, a_ready_in;
  logic        w_HS, w_ACTION, w_A_ZERO, w_STOP;
  logic [9:0]  b_MS_ADDR;
  logic [39:0] b_MS_ZERO;
  logic [5:0]  b_FST_OUT;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int ain_count = 0;

  logic [39:0] mem [0:1023];
  logic [39:0] acc_tmp = '0;
  logic [39:0] acc_val = '0;
  logic        acc_load = 1'b0;

  beat_sequencer dut (
    .w_CLK(clk), .w_RST(rst), .w_RUN(run),
    .b_MS_DATA(ms_data), .b_A_VALUE(acc),
    .ms_ready_out(ms_ready_out), .ms_ready_in(ms_ready_in),
    .a_ready_out(a_ready_out), .a_ready_in(a_ready_in),
    .w_HS(w_HS), .w_ACTION(w_ACTION),
    .b_MS_ADDR(b_MS_ADDR), .b_MS_ZERO(b_MS_ZERO),
    .w_A_ZERO(w_A_ZERO), .b_FST_OUT(b_FST_OUT), .w_STOP(w_STOP)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Store and accumulator environment: act on the edge ending each strobe.
  always @(posedge clk) begin
    if (ms_ready_out) ms_data <= mem[b_MS_ADDR];
    if (a_ready_out) begin
      if (b_FST_OUT == OP_SHR) acc_tmp <= (w_A_ZERO ? 40'd0 : acc) >> 1;
      else                     acc_tmp <= (w_A_ZERO ? 40'd0 : acc) + ms_data;
    end
    if (acc_load)        acc <= acc_val;
    else if (a_ready_in) acc <= acc_tmp;
    if (a_ready_in) ain_count <= ain_count + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model --------------------------------------
  // m_t counts cycles since S1.P0 of the current instruction (0..31).
  logic       m_running = 1'b0, m_stop = 1'b0, m_run_prev = 1'b0;
  int         m_t = 0;
  logic [9:0] m_ci = '0;
  logic [15:0] m_pi = '0;

  always @(negedge clk) begin
    logic [5:0] op;
    logic acc_cls, a3, scan;
    int beat, ph;
    if (rst) begin
      m_running = 0; m_stop = 0; m_run_prev = 0; m_t = 0; m_ci = '0; m_pi = '0;
    end
    op      = m_pi[15:10];
    acc_cls = !(op == OP_CMP || op == OP_JMP || op == OP_STA || op == OP_HLT);
    beat    = m_t / 4;
    ph      = m_t % 4;
    scan    = m_running && (beat % 2 == 0);
    a3      = m_running && (beat == 5);
    chk("hs",      w_HS,         scan);
    chk("action",  w_ACTION,     m_running && (beat % 2 == 1));
    chk("ms_in",   ms_ready_in,  (scan && ph == 3) || (a3 && op == OP_STA && ph == 3));
    chk("ms_out",  ms_ready_out, m_running && (m_t == 12 || (m_t == 20 && (acc_cls || op == OP_JMP))));
    chk("a_out",   a_ready_out,  m_running && m_t == 21 && acc_cls);
    chk("a_in",    a_ready_in,   m_running && m_t == 22 && acc_cls);
    chk("a_zero",  w_A_ZERO,     m_running && m_t == 21 && op == OP_LDA);
    chk("ms_zero", b_MS_ZERO,    (a3 && op == OP_STA && ph == 3) ? {40{1'b1}} : 40'd0);
    chk("addr",    b_MS_ADDR,    a3 ? m_pi[9:0] : m_ci);
    chk("fst",     b_FST_OUT,    op);
    chk("stop",    w_STOP,       m_stop);
    if (!rst) begin
      if (!m_running) begin
        if (run && !m_run_prev) begin m_running = 1; m_t = 0; m_stop = 0; end
      end else begin
        if (m_t == 7)  m_ci = m_ci + 10'd1;
        if (m_t == 13) m_pi = ms_data[15:0];
        if (m_t == 21 && op == OP_JMP) m_ci = ms_data[9:0];
        if (m_t == 21 && op == OP_CMP && acc[39]) m_ci = m_ci + 10'd1;
        if (m_t == 23 && op == OP_HLT) begin m_running = 0; m_stop = 1; m_t = 0; end
        else m_t = (m_t + 1) % 32;
      end
      m_run_prev = run;
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  function automatic logic [39:0] mk(input logic [5:0] fn, input logic [9:0] a);
    return {24'd0, fn, a};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic set_acc(input logic [39:0] v);
    acc_val = v; acc_load = 1'b1;
    @(posedge clk); #1 acc_load = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  endtask

  // Cycle 0 is the S1.P0 cycle following the edge that samples the rise.
  task automatic pulse_run();
    @(posedge clk); #1 run = 1'b1;
    @(posedge clk); #1 start_cyc = cyc; run = 1'b0;
  endtask

  task automatic at_cycle(input int k);
    int n;
    n = 0;
    while (cyc < start_cyc + k && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (cyc != start_cyc + k) chk("cycle_budget", cyc, start_cyc + k);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ain_snap;
    clear_mem();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_addr", b_MS_ADDR, 10'd0);
    chk("reset_hs", w_HS, 1'b0);

    // LDA 20 with line 20 = 5
    mem[1] = mk(OP_LDA, 10'd20); mem[20] = 40'd5;
    set_acc(40'd0);
    pulse_run();
    at_cycle(0);  chk("t1_s1p0_hs", w_HS, 1'b1);
    at_cycle(12); chk("t1_fetch_addr", b_MS_ADDR, 10'd1);
    at_cycle(14); chk("t1_pi_fn", b_FST_OUT, OP_LDA);
    at_cycle(21); chk("t1_azero", w_A_ZERO, 1'b1);
    at_cycle(23); chk("t1_acc", acc, 40'd5);
    at_cycle(44); chk("t1_period_fetch", {ms_ready_out, b_MS_ADDR}, {1'b1, 10'd2});

    // HLT, then resume
    do_reset(); clear_mem();
    mem[1] = mk(OP_HLT, 10'd0); mem[2] = mk(OP_HLT, 10'd0);
    pulse_run();
    at_cycle(23); chk("t2_stop_early", w_STOP, 1'b0);
    at_cycle(24); chk("t2_stop", w_STOP, 1'b1);
    at_cycle(124);
    chk("t2_idle_stop", w_STOP, 1'b1);
    chk("t2_idle_ci", b_MS_ADDR, 10'd1);
    pulse_run();
    at_cycle(0);  chk("t2_stop_clr", w_STOP, 1'b0);
    at_cycle(12); chk("t2_fetch2", {ms_ready_out, b_MS_ADDR}, {1'b1, 10'd2});
    at_cycle(24); chk("t2_stop2", w_STOP, 1'b1);

    // JMP 10 with line 10 = 4
    do_reset(); clear_mem();
    mem[1] = mk(OP_JMP, 10'd10); mem[10] = 40'd4; mem[5] = mk(OP_HLT, 10'd0);
    pulse_run();
    at_cycle(20); chk("t3_jmp_read", {ms_ready_out, b_MS_ADDR}, {1'b1, 10'd10});
    at_cycle(44); chk("t3_jmp_fetch", {ms_ready_out, b_MS_ADDR}, {1'b1, 10'd5});

    // CMP taken / not taken
    do_reset(); clear_mem();
    mem[1] = mk(OP_CMP, 10'd0); mem[2] = mk(OP_HLT, 10'd0); mem[3] = mk(OP_HLT, 10'd0);
    set_acc(40'h80_0000_0000);
    pulse_run();
    at_cycle(44); chk("t4_cmp_neg", b_MS_ADDR, 10'd3);
    do_reset();
    set_acc(40'd7);
    pulse_run();
    at_cycle(44); chk("t4_cmp_pos", b_MS_ADDR, 10'd2);

    // JMP to a line holding 1023: CI wraps to 0
    do_reset(); clear_mem();
    mem[1] = mk(OP_JMP, 10'd7); mem[7] = 40'd1023; mem[0] = mk(OP_HLT, 10'd0);
    pulse_run();
    at_cycle(39); chk("t5_ci_1023", b_MS_ADDR, 10'd1023);
    at_cycle(40); chk("t5_ci_wrap", b_MS_ADDR, 10'd0);
    at_cycle(44); chk("t5_fetch0", {ms_ready_out, b_MS_ADDR}, {1'b1, 10'd0});

    // Reset during A3.P1 of an ADD
    do_reset(); clear_mem();
    mem[1] = mk(OP_ADD, 10'd20); mem[20] = 40'd7;
    set_acc(40'd0);
    pulse_run();
    at_cycle(21);
    chk("t6_pre_aout", a_ready_out, 1'b1);
    ain_snap = ain_count;
    rst = 1'b1;
    #1;
    chk("t6_rst_outs", {ms_ready_out, ms_ready_in, a_ready_out, a_ready_in, w_HS, w_ACTION,
                        w_A_ZERO, w_STOP, b_MS_ADDR, b_FST_OUT, b_MS_ZERO}, '0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("t6_no_ain", ain_count, ain_snap);
    chk("t6_acc", acc, 40'd0);
    chk("t6_idle", {w_HS, w_ACTION}, 2'b00);
    pulse_run();
    at_cycle(12); chk("t6_refetch", {ms_ready_out, b_MS_ADDR}, {1'b1, 10'd1});
    at_cycle(23); chk("t6_add_acc", acc, 40'd7);

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
